// File: rtl/stream_fifo_pkg.sv
// Shared configuration for the stream FIFO slice.
// Holds the IO width, default depth and almost-full margin. Also holds the
// ceil-log2 helper used to size pointers and counters, and the per-edge
// operation encoding used by the top-level control.
package stream_fifo_pkg;

    localparam int IO_WIDTH          = 128;
    localparam int FLAG_BITS         = 2;
    localparam int FIFO_DEPTH        = 16;
    localparam int FIFO_DEPTH_MARGIN = 2;

    // Operation accepted on an edge, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Ceiling log2. Evaluated at elaboration time only.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle.
//   valid : producer has a beat
//   ready : consumer can take a beat
//   data  : beat payload
// master = producer side, slave = consumer side.
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = IO_WIDTH + FLAG_BITS
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage for stream_fifo.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data
// The storage has no reset; contents are only meaningful where the owner
// has written them.
module fifo_ram #(
    parameter int DATA_WIDTH = 130,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with a registered head beat.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   flush        : synchronous clear of all contents
//   s            : write-side stream (slave)
//   m            : read-side stream (master), m.data is registered
//   count        : stored beats, 0..DEPTH
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= DEPTH-AF_MARGIN
//   almost_empty : count <= AE_LEVEL
//   max_count    : high-water mark of count since reset or flush
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = IO_WIDTH + FLAG_BITS,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_MARGIN  = FIFO_DEPTH_MARGIN,
    parameter int AE_LEVEL   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    stream_fifo_if.slave            s,
    stream_fifo_if.master           m,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   max_count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         rd_next;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         max_count_q, max_count_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  push;
    logic                  pop;
    fifo_op_e              op;

    assign s.ready = (count_q != CNT_FULL);
    assign m.valid = (count_q != '0);
    assign m.data  = m_data_q;

    assign push    = s.valid && s.ready && !flush;
    assign pop     = m.valid && m.ready && !flush;
    assign op      = fifo_op_e'({push, pop});
    assign rd_next = rd_ptr_q + PTR_ONE;

    // Every accepted beat goes into the RAM, including the head. The output
    // register mirrors the head, so after a pop the next head is read from
    // the slot behind the current one.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s.data),
        .raddr (rd_next),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        m_data_d = m_data_q;

        case (op)
            OP_PUSH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = count_q + CNT_ONE;
                // Fall-through: a beat into an empty FIFO is the new head.
                if (count_q == '0) begin
                    m_data_d = s.data;
                end
            end
            OP_POP: begin
                rd_ptr_d = rd_next;
                count_d  = count_q - CNT_ONE;
                m_data_d = ram_rdata;
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_next;
                // With one beat stored, the slot behind the head is the one
                // being written this edge, so take the incoming beat directly.
                m_data_d = (count_q == CNT_ONE) ? s.data : ram_rdata;
            end
            default: begin
            end
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        if (flush) begin
            max_count_d = '0;
        end else if (count_d > max_count_q) begin
            max_count_d = count_d;
        end else begin
            max_count_d = max_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            max_count_q <= '0;
            m_data_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
            m_data_q    <= m_data_d;
        end
    end

    assign count        = count_q;
    assign max_count    = max_count_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

    localparam int DW    = 130;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int AEL   = 1;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [4:0] count;
    logic [4:0] max_count;
    logic       full, empty, almost_full, almost_empty;

    stream_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    stream_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    stream_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (AFM),
        .AE_LEVEL   (AEL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .s            (s_if),
        .m            (m_if),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_count    (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of expected beats plus occupancy and high-water mark.
    logic [DW-1:0] exp_q[$];
    int            mdl_cnt = 0;
    int            mdl_max = 0;
    bit            acc_push;
    bit            acc_pop;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Advance one clock edge; return 2 time units after it with outputs settled.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model update + status checks, sampled mid-cycle with inputs stable.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", int'(count), mdl_cnt);
            chk("full", int'(full), int'(mdl_cnt == DEPTH));
            chk("empty", int'(empty), int'(mdl_cnt == 0));
            chk("almost_full", int'(almost_full), int'(mdl_cnt >= DEPTH - AFM));
            chk("almost_empty", int'(almost_empty), int'(mdl_cnt <= AEL));
            chk("s_ready", int'(s_if.ready), int'(mdl_cnt < DEPTH));
            chk("m_valid", int'(m_if.valid), int'(mdl_cnt > 0));
            chk("max_count", int'(max_count), mdl_max);
            if (flush) begin
                exp_q.delete();
                mdl_cnt = 0;
                mdl_max = 0;
            end else begin
                acc_push = s_if.valid && (mdl_cnt < DEPTH);
                acc_pop  = m_if.ready && (mdl_cnt > 0);
                if (acc_push) exp_q.push_back(s_if.data);
                mdl_cnt = mdl_cnt + int'(acc_push) - int'(acc_pop);
                if (mdl_cnt > mdl_max) mdl_max = mdl_cnt;
            end
        end
    end

    // Output monitor: head beat must match the scoreboard front; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && !flush && m_if.valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL m_data: output %0h while nothing expected at %0t", m_if.data, $time);
            end else begin
                chk_d("m_data", m_if.data, exp_q[0]);
                if (m_if.ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_m_valid", int'(m_if.valid), 0);
        chk_d("rst_m_data", m_if.data, '0);
        rst_n = 1'b1;
        step();
        chk("rst_s_ready", int'(s_if.ready), 1);
        chk("rst_empty", int'(empty), 1);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_max_count", int'(max_count), 0);

        // Fill to full with m_ready low.
        for (int i = 0; i < DEPTH; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = DW'(i);
            step();
            chk("fill_count", int'(count), i + 1);
            chk("fill_almost_full", int'(almost_full), int'(i + 1 >= 14));
        end
        s_if.data = DW'(99);
        step();
        chk("full_count", int'(count), 16);
        chk("full_flag", int'(full), 1);
        chk("full_s_ready", int'(s_if.ready), 0);
        s_if.valid = 1'b0;

        // Drain in order.
        m_if.ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk_d("drain_data", m_if.data, DW'(i));
            step();
        end
        m_if.ready = 1'b0;
        chk("drain_empty", int'(empty), 1);
        chk("drain_max_count", int'(max_count), 16);

        // Simultaneous push/pop holding one beat; pointers wrap twice.
        s_if.valid = 1'b1;
        s_if.data  = DW'(256);
        step();
        m_if.ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_if.data = DW'(257 + i);
            step();
            chk("hold_count", int'(count), 1);
            chk_d("hold_data", m_if.data, DW'(257 + i));
        end
        s_if.valid = 1'b0;
        step();
        m_if.ready = 1'b0;
        chk("hold_end_empty", int'(empty), 1);

        // Fall-through latency.
        s_if.valid = 1'b1;
        s_if.data  = DW'(8'hA5);
        step();
        s_if.valid = 1'b0;
        chk("fwft_m_valid", int'(m_if.valid), 1);
        chk_d("fwft_m_data", m_if.data, DW'(8'hA5));
        m_if.ready = 1'b1;
        step();
        m_if.ready = 1'b0;

        // Flush with a concurrent push.
        for (int i = 0; i < 7; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = DW'(512 + i);
            step();
        end
        chk("pre_flush_count", int'(count), 7);
        flush      = 1'b1;
        s_if.data  = DW'(16'hDEAD);
        m_if.ready = 1'b1;
        step();
        flush      = 1'b0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_m_valid", int'(m_if.valid), 0);
        chk("flush_max_count", int'(max_count), 0);
        s_if.valid = 1'b1;
        s_if.data  = DW'(8'h77);
        step();
        s_if.valid = 1'b0;
        chk_d("post_flush_data", m_if.data, DW'(8'h77));
        m_if.ready = 1'b1;
        step();
        m_if.ready = 1'b0;

        // Asynchronous reset in the middle of a random burst.
        for (int i = 0; i < 20; i++) begin
            s_if.valid = ($urandom_range(0, 3) != 0);
            m_if.ready = ($urandom_range(0, 2) == 0);
            s_if.data  = rnd_data();
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_m_valid", int'(m_if.valid), 0);
        chk_d("arst_m_data", m_if.data, '0);
        chk("arst_max_count", int'(max_count), 0);
        chk("arst_s_ready", int'(s_if.ready), 1);
        exp_q.delete();
        mdl_cnt    = 0;
        mdl_max    = 0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        s_if.valid = 1'b1;
        s_if.data  = DW'(8'h3C);
        step();
        s_if.valid = 1'b0;
        chk("post_rst_count", int'(count), 1);
        chk_d("post_rst_data", m_if.data, DW'(8'h3C));
        m_if.ready = 1'b1;
        step();
        m_if.ready = 1'b0;
        chk("post_rst_empty", int'(empty), 1);

        // Random traffic: push-heavy, then pop-heavy, occasional flush.
        for (int i = 0; i < 800; i++) begin
            if (i < 400) begin
                s_if.valid = ($urandom_range(0, 3) != 0);
                m_if.ready = ($urandom_range(0, 2) == 0);
            end else begin
                s_if.valid = ($urandom_range(0, 2) == 0);
                m_if.ready = ($urandom_range(0, 3) != 0);
            end
            flush     = ($urandom_range(0, 63) == 0);
            s_if.data = rnd_data();
            step();
        end
        flush      = 1'b0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        repeat (DEPTH + 2) step();
        m_if.ready = 1'b0;
        chk("final_count", int'(count), 0);
        chk("final_scoreboard", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
